fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fewcore_pkg.sv | 28 ++
 rtl/fq_fifo.sv | 79 +++++++
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fewcore_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fewcore_pkg : shared widths, boot address and queue entry type for fetch
// Revision    : 1.0
// ----------------------------------------------------------------------------
package fewcore_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Sequential fetch address; wraps naturally at 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] addr);
    return addr + XLEN'(INST_BYTES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fq_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fq_fifo : ring buffer of {pc, inst} entries with push, pop, flush and count
// Revision: 1.0
// ----------------------------------------------------------------------------
module fq_fifo
  import fewcore_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fq_entry_t                    push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fq_entry_t                    head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;
  logic             full;

  always_comb begin
    do_push = push & ~flush;
    do_pop  = pop & ~flush & (count_q != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; contents only matter while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_data;
  end

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[head_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && full));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue : instruction fetch issue/pending control in front of fq_fifo
// Revision    : 1.0
// ----------------------------------------------------------------------------
module fetch_queue
  import fewcore_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            originPc,
  input  logic [XLEN-1:0] pcBranch,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] pc_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             pending_q, pending_d;
  logic             discard_q, discard_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   inflight;
  logic             fifo_empty;
  logic             accept;
  logic             resp;
  logic             push;
  logic             pop;
  fq_entry_t        push_entry;
  fq_entry_t        head_entry;

  assign inst_valid = ~fifo_empty;
  assign inst_out   = head_entry.inst;
  assign pc_out     = head_entry.pc;
  assign imem_addr  = fetch_pc_q;

  // Queued entries plus the one in flight must leave room for the response.
  always_comb begin
    inflight        = {1'b0, count} + {{CNT_W{1'b0}}, pending_q};
    imem_req        = ~reset & ~originPc & (inflight < (CNT_W+1)'(DEPTH));
    accept          = imem_req & imem_ready;
    resp            = imem_rvalid & pending_q;
    push            = resp & ~discard_q & ~originPc;
    pop             = inst_valid & inst_ready & ~originPc;
    push_entry.pc   = req_pc_q;
    push_entry.inst = imem_rdata;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    if (originPc) begin
      fetch_pc_d = align_pc(pcBranch);
      // A response landing in the redirect cycle retires the outstanding
      // request; otherwise it is still out there and must be dropped later.
      pending_d  = pending_q & ~imem_rvalid;
      discard_d  = pending_q & ~imem_rvalid;
    end else begin
      if (resp) begin
        pending_d = 1'b0;
        discard_d = 1'b0;
      end
      if (accept) begin
        pending_d  = 1'b1;
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = next_pc(fetch_pc_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= align_pc(RESET_PC);
      req_pc_q   <= '0;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
    end
  end

  fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (originPc),
    .head_data (head_entry),
    .count     (count),
    .empty     (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_queue : directed and random stimulus against a queue-based model
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_fetch_queue;
  import fewcore_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;

  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready  = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        originPc    = 1'b0;
  logic [31:0] pcBranch    = '0;
  logic        inst_valid;
  logic        inst_ready  = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  logic [31:0] w_addr;
  logic        w_req;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata  = '0;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;

  int          n_checks;
  int          n_fails;
  logic [31:0] q_pc[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  bit          m_pend;
  bit          m_disc;
  bit          mem_pend;
  logic [31:0] mem_addr;
  bit          w_mem_pend;
  logic [31:0] w_mem_addr;
  int          wrap_n;
  logic [31:0] w_exp;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .originPc    (originPc),
    .pcBranch    (pcBranch),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .pc_out      (pc_out)
  );

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (WRAP_PC)
  ) dut_w (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (w_addr),
    .imem_req    (w_req),
    .imem_ready  (1'b1),
    .imem_rvalid (w_rvalid),
    .imem_rdata  (w_rdata),
    .originPc    (1'b0),
    .pcBranch    (32'h0),
    .inst_valid  (w_valid),
    .inst_ready  (1'b0),
    .inst_out    (w_inst),
    .pc_out      (w_pc)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check, advance the model, move on.
  task automatic cycle(input bit orig, input logic [31:0] br, input bit rdy, input bit irdy);
    bit exp_req;
    bit exp_valid;
    originPc    = orig;
    pcBranch    = br;
    imem_ready  = rdy;
    inst_ready  = irdy;
    imem_rvalid = mem_pend;
    imem_rdata  = mem_pend ? word_at(mem_addr) : $urandom;
    w_rvalid    = w_mem_pend;
    w_rdata     = word_at(w_mem_addr);
    #1;
    exp_req   = !orig && ((q_pc.size() + int'(m_pend)) < DEPTH);
    exp_valid = (q_pc.size() != 0);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    check("imem_addr", imem_addr, m_pc);
    check("inst_valid", 32'(inst_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("pc_out", pc_out, q_pc[0]);
      check("inst_out", inst_out, word_at(q_pc[0]));
    end
    if (wrap_n < 3 && w_req) begin
      check("wrap_addr", w_addr, w_exp);
      w_exp = w_exp + 32'd4;
      wrap_n++;
    end
    if (orig) begin
      q_pc.delete();
      if (m_pend && mem_pend) begin
        m_pend = 1'b0;
        m_disc = 1'b0;
      end else if (m_pend) begin
        m_disc = 1'b1;
      end
      m_pc = {br[31:2], 2'b00};
    end else begin
      if (exp_valid && irdy) void'(q_pc.pop_front());
      if (m_pend && mem_pend) begin
        if (!m_disc) q_pc.push_back(m_pend_pc);
        m_pend = 1'b0;
        m_disc = 1'b0;
      end
      if (exp_req && rdy) begin
        m_pend    = 1'b1;
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    mem_pend   = imem_req && imem_ready;
    mem_addr   = imem_addr;
    w_mem_pend = w_req;
    w_mem_addr = w_addr;
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_wrap_addr", w_addr, WRAP_PC);
    q_pc.delete();
    m_pc       = 32'h0;
    m_pend     = 1'b0;
    m_disc     = 1'b0;
    mem_pend   = 1'b0;
    w_mem_pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    m_pc       = 32'h0;
    m_pend_pc  = 32'h0;
    m_pend     = 1'b0;
    m_disc     = 1'b0;
    mem_pend   = 1'b0;
    mem_addr   = 32'h0;
    w_mem_pend = 1'b0;
    w_mem_addr = 32'h0;
    wrap_n     = 0;
    w_exp      = WRAP_PC;

    #1 reset = 1'b1;
    #1;
    check("reset_inst_valid", 32'(inst_valid), 32'd0);
    check("reset_imem_req", 32'(imem_req), 32'd0);
    check("reset_imem_addr", imem_addr, 32'h0);
    check("reset_wrap_addr", w_addr, WRAP_PC);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fill with decode stalled: four requests, then the queue is full.
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("fill_req_low", 32'(imem_req), 32'd0);
    check("fill_valid", 32'(inst_valid), 32'd1);
    check("fill_pc_out", pc_out, 32'h0);

    // Streaming with decode always ready.
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("stream_valid", 32'(inst_valid), 32'd1);

    // Redirect while a request is outstanding; target is word-aligned.
    cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_empty", 32'(inst_valid), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("redir_bubble", 32'(inst_valid), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("redir_first_valid", 32'(inst_valid), 32'd1);
    check("redir_first_pc", pc_out, 32'h0000_0100);

    // Back-to-back redirects: the last target wins.
    cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_03FF, 1'b1, 1'b1);
    check("b2b_addr", imem_addr, 32'h0000_03FC);

    // Refill with decode stalled until three entries are held, then reset.
    for (int i = 0; i < 10 && q_pc.size() != 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("pre_reset_valid", 32'(inst_valid), 32'd1);
    mid_reset();
    check("restart_addr", imem_addr, 32'h0);
    // Stray response in the first cycle after release must be ignored.
    mem_pend = 1'b1;
    mem_addr = 32'hDEAD_BEE0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Random mix of redirects, memory stalls and decode back-pressure.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(31) == 0), $urandom,
            ($urandom_range(3) != 0), $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
